fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline; directly upstream of the decode stage.
- Generates the PC and issues in-order word requests to instruction memory (variable latency, valid/ready request, always-accepted response).
- Buffers returned words with their PCs in a small FIFO and drives the 64-bit IF/ID pipeline register {instruction, pc} consumed by decode.
- Handles decode stalls and branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, entries in the fetch buffer; also the maximum in-flight requests; power of 2, ≥2.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in fetch_dec_reg when no valid word is available.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rstn, input, 1, asynchronous active-low reset.
- imem_req_valid, output, 1, request valid.
- imem_req_addr, output, 32, word-aligned fetch address.
- imem_req_ready, input, 1, memory accepts request when valid&&ready.
- imem_rsp_valid, input, 1, response word valid; responses return in request order; always accepted.
- imem_rsp_data, input, 32, instruction word.
- dec_stall, input, 1, hold fetch_dec_reg unchanged this cycle.
- redirect_valid, input, 1, branch/jump taken.
- redirect_pc, input, 32, target; bits [1:0] forced to 0.
- fetch_dec_reg, output, 64, {instruction[63:32], pc[31:0]}, registered.
- fetch_dec_valid, output, 1, fetch_dec_reg holds a real instruction.

Behaviour:
- Reset (async, rstn=0):
  - pc_q=RESET_PC; FIFO empty; in-flight=0; drop_cnt=0; state=IDLE.
  - fetch_dec_reg={NOP_INST,32'h0}; fetch_dec_valid=0; imem_req_valid=0.
  - A reset mid-transaction abandons all in-flight responses; memory is reset by the same rstn.
- FSM:
  - IDLE: one cycle, no request, then RUN.
  - RUN: imem_req_valid=1 when (in-flight + FIFO occupancy) < FIFO_DEPTH and redirect_valid=0; imem_req_addr=pc_q.
    - On handshake, pc_q += 4 (wraps at 2^32) and a FIFO slot is allocated holding the pc, marked unfilled.
  - FLUSH: entered on redirect while in-flight>0; imem_req_valid=0; each response decrements drop_cnt and is discarded; return to RUN when drop_cnt reaches 0.
    - A response arriving in the same cycle as the decrement to 0 is the last dropped one.
- Responses in RUN fill the oldest unfilled slot.
- Output update (when dec_stall=0):
  - If the FIFO head is filled: pop it; fetch_dec_reg={word,pc}; fetch_dec_valid=1.
  - Otherwise: fetch_dec_reg={NOP_INST,32'h0}; fetch_dec_valid=0.
  - A response arriving this cycle is not forwarded the same cycle; minimum latency is req handshake → 1-cycle memory → fetch_dec_reg updated 2 cycles after the handshake.
- dec_stall=1: fetch_dec_reg and fetch_dec_valid hold; FIFO may still fill; requests continue while space remains.
- Redirect (redirect_valid=1, has priority over stall and pop):
  - Next cycle: pc_q=redirect_pc&~3; FIFO cleared.
  - drop_cnt=in-flight, counting a response arriving the same cycle as already consumed.
  - fetch_dec_reg={NOP_INST,0}; fetch_dec_valid=0.
  - State=FLUSH if drop_cnt>0, else RUN.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the later redirect wins; drop_cnt is recomputed from the current in-flight count.
- Full FIFO: no request issued; no overflow is possible by construction.
- Empty FIFO: bubbles are inserted; no underflow.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_fetched (increments on every pop with fetch_dec_valid=1) and perf_flushed (increments by the number of discarded FIFO entries plus dropped responses on each redirect).
  - Both counters reset to 0 and wrap silently.
- Undefined: the counter logic is absent and both ports are driven to 32'h0.

Test Plan:
- Reset release, memory with 1-cycle latency, ready=1, no stall: first request addr 0x0 in cycle 1 after IDLE; fetch_dec_reg = {mem[0],0x0}, {mem[4],0x4}, {mem[8],0x8} on consecutive cycles once streaming; fetch_dec_valid=1.
- dec_stall=1 held for 4 cycles mid-stream: fetch_dec_reg is constant throughout; no more than FIFO_DEPTH requests are outstanding; after release, the sequence continues with no skipped or duplicated PC.
- redirect_valid with redirect_pc=0x103 while 2 requests are in flight (latency 3): the next cycle has valid=0 and bubble {0x00000013,0}; both old responses are dropped; the first new request is addr 0x100; the output shows {mem[0x100],0x100}.
- redirect and dec_stall asserted in the same cycle: the redirect wins and the output becomes a bubble; a second redirect to 0x200 one cycle later: only 0x200-stream instructions reach the output.
- imem_req_ready toggled randomly 0/1 and latency 1–4: the output PC sequence is strictly +4 with no gaps, and each word matches its PC.
- rstn pulsed low while 2 requests are in flight: all outputs return to reset values immediately; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Issues in-order word fetches to instruction memory, buffers returned words
// with their PCs in a small FIFO and drives the IF/ID register used by decode.
// Handles decode stalls and branch/jump redirects from execute.
//
// Optional feature: define FETCH_PERF_CNT_EN to enable the perf_fetched /
// perf_flushed counters; when undefined both ports are tied to zero.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   imem_req_valid     fetch request valid (combinational)
//   imem_req_addr      word-aligned fetch address (current PC)
//   imem_req_ready     memory accepts the request
//   imem_rsp_valid     in-order response valid, always accepted
//   imem_rsp_data      returned instruction word
//   dec_stall          decode holds fetch_dec_reg this cycle
//   redirect_valid     taken branch/jump from execute
//   redirect_pc        redirect target (low two bits ignored)
//   fetch_dec_reg      {instruction, pc} to decode, registered
//   fetch_dec_valid    fetch_dec_reg holds a real instruction
//   perf_fetched       instructions delivered to decode
//   perf_flushed       buffered entries plus responses discarded by redirects
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        dec_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [63:0] fetch_dec_reg,
  output logic        fetch_dec_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic        filled;
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  entry_t        fifo_d [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  // cnt counts allocated slots (filled or awaiting their response)
  logic [CW-1:0] cnt_q, cnt_d;
  // inflight counts outstanding requests; in FLUSH these are all to be dropped
  logic [CW-1:0] inflight_q, inflight_d;
  logic [31:0]   pc_q, pc_d;
  logic [1:0]    state_q, state_d;
  logic [63:0]   dec_q, dec_d;
  logic          dec_valid_q, dec_valid_d;

  logic head_filled_c;
  logic pop_c;
  logic space_c;
  logic hs_c;

  // Pop/request qualification; a slot freed by this cycle's pop may be reused
  // immediately so a depth-2 buffer streams one word per cycle at latency 1.
  always_comb begin
    head_filled_c  = (cnt_q != '0) && fifo_q[head_q].filled;
    pop_c          = head_filled_c && !dec_stall && !redirect_valid;
    space_c        = (cnt_q - CW'(pop_c)) < CW'(FIFO_DEPTH);
    imem_req_valid = (state_q == ST_RUN) && !redirect_valid && space_c;
    hs_c           = imem_req_valid && imem_req_ready;
  end

  assign imem_req_addr   = pc_q;
  assign fetch_dec_reg   = dec_q;
  assign fetch_dec_valid = dec_valid_q;

  // Next-state: FSM, FIFO bookkeeping, IF/ID register
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    fifo_d      = fifo_q;
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    inflight_d  = inflight_q + CW'(hs_c) - CW'(imem_rsp_valid);
    cnt_d       = cnt_q + CW'(hs_c) - CW'(pop_c);

    // Responses fill the oldest unfilled slot; in FLUSH they are discarded
    if ((state_q == ST_RUN) && imem_rsp_valid) begin
      fifo_d[fill_q].filled = 1'b1;
      fifo_d[fill_q].word   = imem_rsp_data;
      fill_d                = fill_q + PW'(1);
    end

    if (hs_c) begin
      fifo_d[tail_q] = '{filled: 1'b0, word: NOP_INST, pc: pc_q};
      tail_d         = tail_q + PW'(1);
      pc_d           = pc_q + 32'd4;
    end

    if (!dec_stall) begin
      if (pop_c) begin
        dec_d       = {fifo_q[head_q].word, fifo_q[head_q].pc};
        dec_valid_d = 1'b1;
        head_d      = head_q + PW'(1);
      end else begin
        dec_d       = {NOP_INST, 32'h0};
        dec_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: if (inflight_d == '0) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    // Redirect overrides stall and pop; a response arriving now is already
    // excluded from inflight_d, so it counts as the one consumed this cycle.
    if (redirect_valid) begin
      pc_d        = redirect_pc & ~32'd3;
      head_d      = '0;
      tail_d      = '0;
      fill_d      = '0;
      cnt_d       = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i].filled = 1'b0;
      dec_d       = {NOP_INST, 32'h0};
      dec_valid_d = 1'b0;
      state_d     = (inflight_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      inflight_q  <= '0;
      dec_q       <= {NOP_INST, 32'h0};
      dec_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  // cnt_q covers filled entries and the unfilled slots whose responses are
  // dropped; in FLUSH it is zero, so re-redirects never double count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (pop_c)          perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_flushed_q <= perf_flushed_q + 32'(cnt_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: in-order variable-latency memory model, expected
// {word, pc} pushed into a queue at each request handshake, and a separate
// monitor that compares every IF/ID update against that queue.
module tb_fetch_stage;

  localparam int unsigned DEPTH  = 2;
  localparam logic [63:0] BUBBLE = {32'h0000_0013, 32'h0000_0000};

  logic        clk;
  logic        rstn;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] fetch_dec_reg;
  logic        fetch_dec_valid;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  fetch_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .dec_stall       (dec_stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_dec_reg   (fetch_dec_reg),
    .fetch_dec_valid (fetch_dec_valid),
    .perf_fetched    (perf_fetched),
    .perf_flushed    (perf_flushed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          pops = 0;
  logic        chk_addr_en = 1'b0;
  logic [31:0] chk_addr_want = '0;
  logic [63:0] last_reg = BUBBLE;
  logic        last_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // One cycle: drive at edge+2, record a handshake at edge+3
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc, input logic rdy);
    req_t r;
    @(posedge clk);
    #2;
    cyc++;
    dec_stall      = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if (redir) exp_q.delete();
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      r.addr   = imem_req_addr;
      r.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      mq.push_back(r);
      exp_q.push_back({mem_word(imem_req_addr), imem_req_addr});
      chk("outstanding_le_depth", 64'(mq.size() <= DEPTH), 64'd1);
      if (chk_addr_en) begin
        chk("first_req_addr", 64'(imem_req_addr), 64'(chk_addr_want));
        chk_addr_en = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_reg", fetch_dec_reg, BUBBLE);
    chk("rst_valid", 64'(fetch_dec_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    chk("rst_perf_flushed", 64'(perf_flushed), 64'd0);
  endtask

  // Release reset: IDLE cycle has no request, next cycle requests RESET_PC
  task automatic release_reset();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
    chk("idle_no_req", 64'(imem_req_valid), 64'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr0", 64'(imem_req_addr), 64'h0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      budget++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(pops));
`else
    chk("perf_fetched_tied", 64'(perf_fetched), 64'd0);
`endif
  endtask

  // Monitor: compare the IF/ID register after every edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        chk("reset_reg", fetch_dec_reg, BUBBLE);
        chk("reset_valid", 64'(fetch_dec_valid), 64'd0);
        pops = 0;
      end else if (redirect_valid) begin
        chk("redirect_bubble", fetch_dec_reg, BUBBLE);
        chk("redirect_valid0", 64'(fetch_dec_valid), 64'd0);
      end else if (dec_stall) begin
        chk("stall_hold_reg", fetch_dec_reg, last_reg);
        chk("stall_hold_valid", 64'(fetch_dec_valid), 64'(last_valid));
      end else if (fetch_dec_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h want none (t=%0t)", fetch_dec_reg, $time);
        end else begin
          chk("output_seq", fetch_dec_reg, exp_q[0]);
          exp_q.delete(0);
          pops++;
        end
      end else begin
        chk("idle_bubble", fetch_dec_reg, BUBBLE);
      end
      last_reg   = fetch_dec_reg;
      last_valid = fetch_dec_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn           = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dec_stall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    rstn = 1'b0;
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    release_reset();

    // Streaming, latency 1, no stall
    lat = 1;
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall held 4 cycles mid-stream, then resume
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x103 with requests in flight at latency 3
    lat = 3;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_addr_en   = 1'b1;
    chk_addr_want = 32'h100;
    step(1'b0, 1'b1, 32'h103, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redirect_req_seen", 64'(chk_addr_en), 64'd0);

    // Redirect with stall, then a second redirect to 0x200
    lat = 2;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_addr_en   = 1'b1;
    chk_addr_want = 32'h200;
    step(1'b1, 1'b1, 32'h180, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redirect2_req_seen", 64'(chk_addr_en), 64'd0);

    // Random ready and latency 1..4, occasional stalls
    for (int i = 0; i < 80; i++) begin
      lat = int'($urandom_range(4, 1));
      step(($urandom_range(9, 0) == 0), 1'b0, 32'h0, 1'($urandom_range(1, 0)));
    end
    drain();

    // Reset pulsed with requests in flight
    lat = 3;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    rstn           = 1'b0;
    dec_stall      = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    mq.delete();
    exp_q.delete();
    last_due = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();
    lat = 1;
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
